// File: rtl/output_deskew_pkg.sv
// rtl/output_deskew_pkg.sv - shared accelerator constants and lane word type for the output deskew
package output_deskew_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N          = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_word_t;
endpackage

// File: rtl/output_deskew_if.sv
// rtl/output_deskew_if.sv - lane bus between systolic array edge, deskew and writeback
interface output_deskew_if
  import output_deskew_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
  logic                         en;
  logic                         clr;
  logic signed [DATA_WIDTH-1:0] din [N];
  logic [N-1:0]                 din_valid;
  logic signed [DATA_WIDTH-1:0] dout [N];
  logic                         dout_valid;
  logic [CNT_WIDTH-1:0]         out_count;
  logic                         misalign_err;

  modport master (
    output en, clr, din, din_valid,
    input  dout, dout_valid, out_count, misalign_err
  );

  modport slave (
    input  en, clr, din, din_valid,
    output dout, dout_valid, out_count, misalign_err
  );
endinterface

// File: rtl/output_deskew_en_reg_async.sv
// rtl/output_deskew_en_reg_async.sv - one enabled deskew stage carrying a word and its valid bit
module en_reg_async
  import output_deskew_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] q_o,
  output logic         v_o
);
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      data_d  = d_i;
      valid_d = v_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o = data_q;
  assign v_o = valid_q;
endmodule

// File: rtl/output_deskew.sv
// rtl/output_deskew.sv - realigns the systolic output wavefront; DESKEW_ALIGN_CHECK_EN adds the misalign flag
module output_deskew
  import output_deskew_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  output_deskew_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [N-1:0] lane_v;
  logic         vec_valid;

  // Lane y needs N-1-y stages so its word lines up with the undelayed top lane.
  for (genvar y = 0; y < N; y++) begin : g_lane
    localparam int S = N - 1 - y;
    logic [DATA_WIDTH-1:0] d_w [S+1];
    logic                  v_w [S+1];

    assign d_w[0] = bus.din[y];
    assign v_w[0] = bus.din_valid[y];

    for (genvar s = 0; s < S; s++) begin : g_stage
      en_reg_async #(.W(DATA_WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (bus.en),
        .clr_i (bus.clr),
        .d_i   (d_w[s]),
        .v_i   (v_w[s]),
        .q_o   (d_w[s+1]),
        .v_o   (v_w[s+1])
      );
    end

    assign bus.dout[y] = d_w[S];
    assign lane_v[y]   = v_w[S];
  end

  assign vec_valid      = bus.en & (&lane_v);
  assign bus.dout_valid = vec_valid;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (vec_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_count = cnt_q;

`ifdef DESKEW_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic mixed;

  // A partially valid vector means the upstream skew was broken.
  assign mixed = (lane_v != '0) && (lane_v != '1);

  always_comb begin
    err_d = err_q;
    if (bus.clr) begin
      err_d = 1'b0;
    end else if (bus.en && mixed) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: doc/output_deskew.md
Name: output_deskew

Overview:
- Re-aligns the diagonal wavefront leaving the systolic array.
- The input-side skew delays lane y by y cycles; this block delays lane y by N-1-y enabled cycles, so every lane arrives at the output in the same cycle.
- Sits between the systolic array output edge and the accumulator/writeback stage.
- Also tracks per-lane valid, flags aligned vectors and counts them.

Parameters:
- DATA_WIDTH, 16, width of each signed lane word.
- N, 4, number of lanes (≥1).
- CNT_WIDTH, 16, width of the aligned-vector counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; stages shift only when en=1.
- clr  input  1  synchronous clear of stages, counter and error flag; priority over en.
- din  input  signed [DATA_WIDTH-1:0] x N (unpacked)  skewed lane data from the array.
- din_valid  input  N  per-lane valid.
- dout  output  signed [DATA_WIDTH-1:0] x N (unpacked)  aligned lane data.
- dout_valid  output  1  aligned vector present this cycle.
- out_count  output  CNT_WIDTH  saturating count of aligned vectors emitted.
- misalign_err  output  1  sticky partial-valid flag (see Optional Feature).

Behaviour:
- Reset: asynchronous and active-low; all state clears immediately, not on the next edge.
- Lane y has N-1-y register stages on data and valid (a valid bit travels with each word).
  - Lane N-1 has zero stages: dout[N-1]=din[N-1] and its valid is din_valid[N-1], both combinational.
- Stage update:
  - en=1, clr=0: each stage loads its predecessor.
  - en=0: all stages hold.
  - clr=1: data stages load 0 and valid stages load 0, regardless of en.
- Latency: a word entering lane y while en=1 reaches dout[y] after N-1-y enabled cycles.
  - Lane y input at enabled cycle t+y appears at enabled cycle t+N-1, for every y.
- Validity: lane_v[y] is the last-stage valid of lane y; lane_v[N-1] is din_valid[N-1].
  - dout_valid = en & (AND of lane_v[0..N-1]); combinational from those terms.
- out_count:
  - Increments by 1 on each clk edge where dout_valid=1 and clr=0.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - clr=1 forces it to 0.
- Reset values:
  - All stages 0, out_count=0, misalign_err=0.
  - dout[y]=0 for y<N-1; dout[N-1] follows din[N-1].
  - dout_valid=0 for N>1.
- N=1 is a pure passthrough:
  - dout[0]=din[0], dout_valid=en&din_valid[0].
  - Counter and error flag behave as for N>1.
- Reset mid-stream: in-flight words are discarded; no partial vector is emitted afterwards.
  - Leftover valids are cleared, so a stale partial wavefront cannot raise an error.
- Simultaneous clr and dout_valid=1: clr wins; the counter goes to 0, not 1.

Optional Feature:
- Macro: DESKEW_ALIGN_CHECK_EN.
- Defined:
  - misalign_err is set when en=1 and lane_v is neither all-0 nor all-1, i.e. a skew violation upstream.
  - Once set, it stays set until rst_n or clr.
  - Setting and clr in the same cycle: clr wins.
- Undefined:
  - misalign_err is tied to 0, no check logic is built, and the port remains present.

Decomposition:
- Shared package (existing accelerator package):
  - Default DATA_WIDTH=16 and N=4 constants.
  - A lane_word_t typedef, signed [DATA_WIDTH-1:0].
- Sub-module en_reg_async: enable register with async active-low reset, synchronous clear and a valid bit.
  - Instantiated in a triangular generate loop, lane y having N-1-y instances.
- Counter and error logic stay in the top module.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle with din[3]=0x1234 (N=4) -> dout[0..2]=0 immediately, dout[3]=0x1234, dout_valid=0, out_count=0, misalign_err=0.
- Aligned stream: en=1; lane y receives 100+k with valid at cycle k+y, k=0..7 -> from cycle 3 to cycle 10 all dout[y]=100+(cycle-3), dout_valid=1, out_count=8, misalign_err=0.
- Stall: as in the aligned stream, but en=0 for cycles 5-6 with inputs held -> outputs held, dout_valid=0 and out_count frozen during the stall; the stream resumes aligned and out_count ends at 8.
- Misalignment (macro on): single din_valid[0]=1 pulse at cycle 0, other lanes idle -> at cycle 3 lane_v=4'b0001, dout_valid=0, misalign_err=1 and stays 1; clr -> 0.
- Saturation: CNT_WIDTH=4, 20 aligned vectors -> out_count=15 after the 15th vector and stays 15; clr together with a valid vector -> out_count=0.
- Mid-stream clr: clr=1 at cycle 4 of the aligned stream -> the next cycle has dout[0..2]=0 and dout_valid=0; fresh skewed data afterwards realigns after 3 cycles with no error.
